// File: rtl/exu_bju_pipe_if.sv
// ---------------------------------------------------------------------------
// exu_bju_pipe_if
// Bundle of every non-clock signal of the EXU branch/jump unit.
//   master : the IDU/RTU side. It drives issue, flush and ROB-ready, and it
//            observes issue-ready, completion, link writeback and redirect.
//   slave  : the branch/jump unit itself.
// Signal names keep the IDU/RTU/EXU naming used by the surrounding pipeline.
// ---------------------------------------------------------------------------
interface exu_bju_pipe_if #(
  parameter int XLEN   = 64,
  parameter int IID_W  = 5,
  parameter int PREG_W = 6
);
  // flush from retire unit
  logic              rtu_global_flush;
  // issue channel
  logic              idu_exu_bju_vld;
  logic              idu_exu_bju_rdy;
  logic [IID_W-1:0]  idu_exu_bju_iid;
  logic [6:0]        idu_exu_bju_opcode;
  logic [2:0]        idu_exu_bju_funct3;
  logic [XLEN-1:0]   idu_exu_bju_pc;
  logic [XLEN-1:0]   idu_exu_bju_psrc1_value;
  logic [XLEN-1:0]   idu_exu_bju_psrc2_value;
  logic              idu_exu_bju_pdst_vld;
  logic [PREG_W-1:0] idu_exu_bju_pdst;
  logic [XLEN-1:0]   idu_exu_bju_imm;
  logic              idu_exu_bju_pred_taken;
  logic [XLEN-1:0]   idu_exu_bju_pred_addr;
  // completion channel
  logic              rtu_exu_bju_rdy;
  logic              exu_rtu_rob_bju_complete;
  logic [IID_W-1:0]  exu_rtu_rob_bju_iid;
  logic              exu_rtu_rob_bju_mispred;
  // link writeback and redirect
  logic              exu_idu_rf_bju_wb_vld;
  logic [PREG_W-1:0] exu_idu_rf_bju_wb_preg;
  logic [XLEN-1:0]   exu_idu_rf_bju_wb_data;
  logic              exu_idu_rf_bju_pcjump_vld;
  logic [XLEN-1:0]   exu_idu_rf_bju_pcjump_addr;

  modport master (
    output rtu_global_flush,
    output idu_exu_bju_vld,
    input  idu_exu_bju_rdy,
    output idu_exu_bju_iid,
    output idu_exu_bju_opcode,
    output idu_exu_bju_funct3,
    output idu_exu_bju_pc,
    output idu_exu_bju_psrc1_value,
    output idu_exu_bju_psrc2_value,
    output idu_exu_bju_pdst_vld,
    output idu_exu_bju_pdst,
    output idu_exu_bju_imm,
    output idu_exu_bju_pred_taken,
    output idu_exu_bju_pred_addr,
    output rtu_exu_bju_rdy,
    input  exu_rtu_rob_bju_complete,
    input  exu_rtu_rob_bju_iid,
    input  exu_rtu_rob_bju_mispred,
    input  exu_idu_rf_bju_wb_vld,
    input  exu_idu_rf_bju_wb_preg,
    input  exu_idu_rf_bju_wb_data,
    input  exu_idu_rf_bju_pcjump_vld,
    input  exu_idu_rf_bju_pcjump_addr
  );

  modport slave (
    input  rtu_global_flush,
    input  idu_exu_bju_vld,
    output idu_exu_bju_rdy,
    input  idu_exu_bju_iid,
    input  idu_exu_bju_opcode,
    input  idu_exu_bju_funct3,
    input  idu_exu_bju_pc,
    input  idu_exu_bju_psrc1_value,
    input  idu_exu_bju_psrc2_value,
    input  idu_exu_bju_pdst_vld,
    input  idu_exu_bju_pdst,
    input  idu_exu_bju_imm,
    input  idu_exu_bju_pred_taken,
    input  idu_exu_bju_pred_addr,
    input  rtu_exu_bju_rdy,
    output exu_rtu_rob_bju_complete,
    output exu_rtu_rob_bju_iid,
    output exu_rtu_rob_bju_mispred,
    output exu_idu_rf_bju_wb_vld,
    output exu_idu_rf_bju_wb_preg,
    output exu_idu_rf_bju_wb_data,
    output exu_idu_rf_bju_pcjump_vld,
    output exu_idu_rf_bju_pcjump_addr
  );
endinterface

// File: rtl/exu_bju_pipe.sv
// ---------------------------------------------------------------------------
// exu_bju_pipe
// Two-stage branch/jump unit.
//   E1 latches the raw issued micro-op.
//   The E1->E2 boundary resolves JAL / JALR / conditional branches, compares
//   the outcome against the front-end prediction, and registers the
//   completion, link writeback and redirect.
// A small kill FSM drops wrong-path issues after a mispredict until the
// retire unit flushes.
// Ports:
//   clk     : clock
//   rst_clk : asynchronous reset, active-high
//   bju     : exu_bju_pipe_if.slave. It carries flush, the issue handshake,
//             the ROB completion handshake, link writeback and redirect.
// ---------------------------------------------------------------------------
module exu_bju_pipe #(
  parameter int XLEN   = 64,
  parameter int IID_W  = 5,
  parameter int PREG_W = 6
) (
  input  logic           clk,
  input  logic           rst_clk,
  exu_bju_pipe_if.slave  bju
);

  localparam logic [6:0]      OPC_JAL    = 7'b1101111;
  localparam logic [6:0]      OPC_JALR   = 7'b1100111;
  localparam logic [6:0]      OPC_BRANCH = 7'b1100011;
  localparam logic [XLEN-1:0] PC_STEP    = {{(XLEN-3){1'b0}}, 3'b100};
  localparam logic [XLEN-1:0] JALR_MASK  = {{(XLEN-1){1'b1}}, 1'b0};

  typedef enum logic [0:0] {
    ST_NORMAL = 1'b0,
    ST_KILL   = 1'b1
  } kill_state_e;

  // E1 stage registers
  logic              r_e1_vld;
  logic [IID_W-1:0]  r_e1_iid;
  logic [6:0]        r_e1_opcode;
  logic [2:0]        r_e1_funct3;
  logic [XLEN-1:0]   r_e1_pc;
  logic [XLEN-1:0]   r_e1_src1;
  logic [XLEN-1:0]   r_e1_src2;
  logic              r_e1_pdst_vld;
  logic [PREG_W-1:0] r_e1_pdst;
  logic [XLEN-1:0]   r_e1_imm;
  logic              r_e1_pred_taken;
  logic [XLEN-1:0]   r_e1_pred_addr;

  // E2 stage registers (these drive the outputs directly)
  logic              r_e2_vld;
  logic [IID_W-1:0]  r_e2_iid;
  logic              r_e2_mispred;
  logic              r_e2_wb_vld;
  logic [PREG_W-1:0] r_e2_wb_preg;
  logic [XLEN-1:0]   r_e2_wb_data;
  logic              r_pcjump_vld;
  logic [XLEN-1:0]   r_pcjump_addr;

  kill_state_e       r_state;
  kill_state_e       w_state_nxt;

  // resolve / handshake wires
  logic              w_is_jal;
  logic              w_is_jalr;
  logic              w_is_br;
  logic              w_is_ctrl;
  logic              w_cond_taken;
  logic              w_taken;
  logic [XLEN-1:0]   w_link;
  logic [XLEN-1:0]   w_br_target;
  logic [XLEN-1:0]   w_jalr_target;
  logic [XLEN-1:0]   w_target;
  logic [XLEN-1:0]   w_actual_next;
  logic              w_mispred;
  logic              w_link_req;
  logic              w_e2_fire;
  logic              w_e1_adv;
  logic              w_kill_mode;
  logic              w_kill_trig;
  logic              w_issue_rdy;
  logic              w_issue_take;

  // Major-opcode decode of the op sitting in E1
  always_comb begin
    w_is_jal  = 1'b0;
    w_is_jalr = 1'b0;
    w_is_br   = 1'b0;
    case (r_e1_opcode)
      OPC_JAL:    w_is_jal  = 1'b1;
      OPC_JALR:   w_is_jalr = (r_e1_funct3 == 3'b000); // JALR with nonzero funct3 is NOP-class
      OPC_BRANCH: w_is_br   = 1'b1;
      default:    w_is_jal  = 1'b0;
    endcase
  end

  // Branch condition evaluation by funct3 (010/011 are never taken)
  always_comb begin
    w_cond_taken = 1'b0;
    case (r_e1_funct3)
      3'b000:  w_cond_taken = (r_e1_src1 == r_e1_src2);
      3'b001:  w_cond_taken = (r_e1_src1 != r_e1_src2);
      3'b100:  w_cond_taken = ($signed(r_e1_src1) <  $signed(r_e1_src2));
      3'b101:  w_cond_taken = ($signed(r_e1_src1) >= $signed(r_e1_src2));
      3'b110:  w_cond_taken = (r_e1_src1 <  r_e1_src2);
      3'b111:  w_cond_taken = (r_e1_src1 >= r_e1_src2);
      default: w_cond_taken = 1'b0;
    endcase
  end

  assign w_is_ctrl     = w_is_jal | w_is_jalr | w_is_br;
  assign w_link        = r_e1_pc + PC_STEP;
  assign w_br_target   = r_e1_pc + r_e1_imm;
  assign w_jalr_target = (r_e1_src1 + r_e1_imm) & JALR_MASK;
  assign w_taken       = w_is_jal | w_is_jalr | (w_is_br & w_cond_taken);
  assign w_link_req    = r_e1_pdst_vld & (w_is_jal | w_is_jalr);

  // Target and correct-path selection
  always_comb begin
    if (w_is_jalr) begin
      w_target = w_jalr_target;
    end else begin
      w_target = w_br_target;
    end
    if (w_taken) begin
      w_actual_next = w_target;
    end else begin
      w_actual_next = w_link;
    end
  end

  // A taken prediction is only correct if it also named the right target;
  // NOP-class ops can never mispredict.
  assign w_mispred = w_is_ctrl &
                     ((w_taken != r_e1_pred_taken) |
                      (w_taken & r_e1_pred_taken & (w_target != r_e1_pred_addr)));

  // Pipeline handshakes
  assign w_e2_fire    = r_e2_vld & bju.rtu_exu_bju_rdy;
  assign w_e1_adv     = r_e1_vld & (~r_e2_vld | bju.rtu_exu_bju_rdy);
  assign w_kill_trig  = ~w_kill_mode & w_e1_adv & w_mispred;
  assign w_issue_rdy  = w_kill_mode | ~r_e1_vld | w_e1_adv;
  // A wrong-path issue arriving at the mispredict edge is dropped as well.
  assign w_issue_take = bju.idu_exu_bju_vld & w_issue_rdy & ~bju.rtu_global_flush &
                        ~w_kill_mode & ~w_kill_trig;

  // Kill FSM: state register
  always_ff @(posedge clk or posedge rst_clk) begin
    if (rst_clk) begin
      r_state <= ST_NORMAL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Kill FSM: next-state logic (flush has priority over entering KILL)
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_NORMAL: begin
        if (bju.rtu_global_flush) begin
          w_state_nxt = ST_NORMAL;
        end else if (w_kill_trig) begin
          w_state_nxt = ST_KILL;
        end else begin
          w_state_nxt = ST_NORMAL;
        end
      end
      ST_KILL: begin
        if (bju.rtu_global_flush) begin
          w_state_nxt = ST_NORMAL;
        end else begin
          w_state_nxt = ST_KILL;
        end
      end
      default: w_state_nxt = ST_NORMAL;
    endcase
  end

  // Kill FSM: output decode
  always_comb begin
    w_kill_mode = 1'b0;
    case (r_state)
      ST_NORMAL: w_kill_mode = 1'b0;
      ST_KILL:   w_kill_mode = 1'b1;
      default:   w_kill_mode = 1'b0;
    endcase
  end

  // E1 occupancy: cleared by flush, by advancing, and always while killing
  always_ff @(posedge clk or posedge rst_clk) begin
    if (rst_clk) begin
      r_e1_vld <= 1'b0;
    end else if (bju.rtu_global_flush) begin
      r_e1_vld <= 1'b0;
    end else if (w_issue_take) begin
      r_e1_vld <= 1'b1;
    end else if (w_e1_adv | w_kill_mode) begin
      r_e1_vld <= 1'b0;
    end else begin
      r_e1_vld <= r_e1_vld;
    end
  end

  // E1 payload capture on every accepted issue
  always_ff @(posedge clk or posedge rst_clk) begin
    if (rst_clk) begin
      r_e1_iid        <= {IID_W{1'b0}};
      r_e1_opcode     <= 7'b0000000;
      r_e1_funct3     <= 3'b000;
      r_e1_pc         <= {XLEN{1'b0}};
      r_e1_src1       <= {XLEN{1'b0}};
      r_e1_src2       <= {XLEN{1'b0}};
      r_e1_pdst_vld   <= 1'b0;
      r_e1_pdst       <= {PREG_W{1'b0}};
      r_e1_imm        <= {XLEN{1'b0}};
      r_e1_pred_taken <= 1'b0;
      r_e1_pred_addr  <= {XLEN{1'b0}};
    end else if (w_issue_take) begin
      r_e1_iid        <= bju.idu_exu_bju_iid;
      r_e1_opcode     <= bju.idu_exu_bju_opcode;
      r_e1_funct3     <= bju.idu_exu_bju_funct3;
      r_e1_pc         <= bju.idu_exu_bju_pc;
      r_e1_src1       <= bju.idu_exu_bju_psrc1_value;
      r_e1_src2       <= bju.idu_exu_bju_psrc2_value;
      r_e1_pdst_vld   <= bju.idu_exu_bju_pdst_vld;
      r_e1_pdst       <= bju.idu_exu_bju_pdst;
      r_e1_imm        <= bju.idu_exu_bju_imm;
      r_e1_pred_taken <= bju.idu_exu_bju_pred_taken;
      r_e1_pred_addr  <= bju.idu_exu_bju_pred_addr;
    end else begin
      r_e1_iid        <= r_e1_iid;
    end
  end

  // E2 result register. A new op replaces a draining one with no bubble.
  // The redirect is set only on the load edge, so it is a single pulse
  // even when completion stalls.
  always_ff @(posedge clk or posedge rst_clk) begin
    if (rst_clk) begin
      r_e2_vld      <= 1'b0;
      r_e2_iid      <= {IID_W{1'b0}};
      r_e2_mispred  <= 1'b0;
      r_e2_wb_vld   <= 1'b0;
      r_e2_wb_preg  <= {PREG_W{1'b0}};
      r_e2_wb_data  <= {XLEN{1'b0}};
      r_pcjump_vld  <= 1'b0;
      r_pcjump_addr <= {XLEN{1'b0}};
    end else if (bju.rtu_global_flush) begin
      r_e2_vld      <= 1'b0;
      r_e2_iid      <= {IID_W{1'b0}};
      r_e2_mispred  <= 1'b0;
      r_e2_wb_vld   <= 1'b0;
      r_e2_wb_preg  <= {PREG_W{1'b0}};
      r_e2_wb_data  <= {XLEN{1'b0}};
      r_pcjump_vld  <= 1'b0;
      r_pcjump_addr <= {XLEN{1'b0}};
    end else if (w_e1_adv) begin
      r_e2_vld      <= 1'b1;
      r_e2_iid      <= r_e1_iid;
      r_e2_mispred  <= w_mispred;
      r_e2_wb_vld   <= w_link_req;
      r_e2_wb_preg  <= r_e1_pdst;
      r_e2_wb_data  <= w_link;
      r_pcjump_vld  <= w_mispred;
      if (w_mispred) begin
        r_pcjump_addr <= w_actual_next;
      end else begin
        r_pcjump_addr <= r_pcjump_addr;
      end
    end else if (w_e2_fire) begin
      r_e2_vld      <= 1'b0;
      r_e2_mispred  <= 1'b0;
      r_e2_wb_vld   <= 1'b0;
      r_pcjump_vld  <= 1'b0;
    end else begin
      r_pcjump_vld  <= 1'b0;
    end
  end

  assign bju.idu_exu_bju_rdy            = w_issue_rdy;
  assign bju.exu_rtu_rob_bju_complete   = r_e2_vld;
  assign bju.exu_rtu_rob_bju_iid        = r_e2_iid;
  assign bju.exu_rtu_rob_bju_mispred    = r_e2_mispred;
  assign bju.exu_idu_rf_bju_wb_vld      = r_e2_wb_vld;
  assign bju.exu_idu_rf_bju_wb_preg     = r_e2_wb_preg;
  assign bju.exu_idu_rf_bju_wb_data     = r_e2_wb_data;
  assign bju.exu_idu_rf_bju_pcjump_vld  = r_pcjump_vld;
  assign bju.exu_idu_rf_bju_pcjump_addr = r_pcjump_addr;

endmodule

// File: tb/tb_exu_bju_pipe.sv
// ---------------------------------------------------------------------------
// tb_exu_bju_pipe
// Directed scenarios plus randomized traffic for exu_bju_pipe.
// Expected behaviour comes from a queue-based reference model. The model
// resolves each op with plain arithmetic. It tracks in-flight ops as a
// list of at most two entries and keeps a kill flag.
// ---------------------------------------------------------------------------
module tb_exu_bju_pipe;

  typedef struct packed {
    logic [4:0]  iid;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [63:0] pc;
    logic [63:0] s1;
    logic [63:0] s2;
    logic [63:0] imm;
    logic        pdv;
    logic [5:0]  pdst;
    logic        pt;
    logic [63:0] paddr;
  } op_t;

  typedef struct packed {
    op_t op;
    logic in_e2;
  } slot_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  slot_t       mq[$];
  logic        m_kill;
  logic        m_pulse;
  logic [63:0] m_pulse_addr;
  logic [4:0]  next_iid;

  exu_bju_pipe_if #(.XLEN(64), .IID_W(5), .PREG_W(6)) bif ();

  exu_bju_pipe #(.XLEN(64), .IID_W(5), .PREG_W(6)) dut (
    .clk     (clk),
    .rst_clk (rst),
    .bju     (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference resolution of one op, straight from the ISA rules
  function automatic void ref_op(input op_t o, output logic taken, output logic [63:0] target,
                                 output logic mis, output logic wbv, output logic [63:0] link);
    logic jal, jalr, br;
    jal    = (o.opc == 7'b1101111);
    jalr   = (o.opc == 7'b1100111) && (o.f3 == 3'b000);
    br     = (o.opc == 7'b1100011);
    link   = o.pc + 64'd4;
    target = o.pc + o.imm;
    taken  = 1'b0;
    if (jal) begin
      taken = 1'b1;
    end else if (jalr) begin
      taken  = 1'b1;
      target = (o.s1 + o.imm) & ~64'd1;
    end else if (br) begin
      case (o.f3)
        3'd0:    taken = (o.s1 == o.s2);
        3'd1:    taken = (o.s1 != o.s2);
        3'd4:    taken = ($signed(o.s1) <  $signed(o.s2));
        3'd5:    taken = ($signed(o.s1) >= $signed(o.s2));
        3'd6:    taken = (o.s1 <  o.s2);
        3'd7:    taken = (o.s1 >= o.s2);
        default: taken = 1'b0;
      endcase
    end
    mis = (jal || jalr || br) && ((taken != o.pt) || (taken && o.pt && (target != o.paddr)));
    wbv = o.pdv && (jal || jalr);
  endfunction

  function automatic op_t mk_op(input logic [4:0] iid, input logic [6:0] opc, input logic [2:0] f3,
                                input logic [63:0] pc, input logic [63:0] s1, input logic [63:0] s2,
                                input logic [63:0] imm, input logic pdv, input logic [5:0] pdst,
                                input logic pt, input logic [63:0] paddr);
    op_t o;
    o.iid = iid; o.opc = opc; o.f3 = f3; o.pc = pc; o.s1 = s1; o.s2 = s2;
    o.imm = imm; o.pdv = pdv; o.pdst = pdst; o.pt = pt; o.paddr = paddr;
    return o;
  endfunction

  function automatic op_t rand_op(input logic [4:0] iid);
    op_t o;
    logic [31:0] r;
    logic tk, mis, wbv;
    logic [63:0] tgt, lnk;
    int pick;
    pick   = $urandom_range(0, 7);
    o      = '0;
    o.iid  = iid;
    o.f3   = 3'($urandom_range(0, 7));
    case (pick)
      0, 1:    o.opc = 7'b1101111;
      2: begin
        o.opc = 7'b1100111;
        if ($urandom_range(0, 3) != 0) o.f3 = 3'b000;
      end
      3, 4, 5: o.opc = 7'b1100011;
      6:       o.opc = 7'b0110011;
      default: o.opc = 7'($urandom);
    endcase
    o.pc   = {$urandom, $urandom};
    o.s1   = ($urandom_range(0, 1) == 0) ? 64'($urandom_range(0, 7)) : {$urandom, $urandom};
    o.s2   = ($urandom_range(0, 2) == 0) ? o.s1 : {$urandom, $urandom};
    r      = $urandom;
    o.imm  = {{44{r[19]}}, r[19:0]};
    o.pdv  = 1'($urandom_range(0, 1));
    o.pdst = 6'($urandom);
    ref_op(o, tk, tgt, mis, wbv, lnk);
    if ($urandom_range(0, 3) != 0) begin
      o.pt    = tk;
      o.paddr = tk ? tgt : {$urandom, $urandom};
    end else begin
      o.pt    = 1'($urandom_range(0, 1));
      o.paddr = ($urandom_range(0, 1) == 0) ? tgt : {$urandom, $urandom};
    end
    return o;
  endfunction

  // Compare registered outputs against the model state after the last edge
  task automatic check_outputs();
    logic tk, mis, wbv;
    logic [63:0] tgt, lnk;
    if (mq.size() > 0 && mq[0].in_e2) begin
      ref_op(mq[0].op, tk, tgt, mis, wbv, lnk);
      check_eq("complete", 64'(bif.exu_rtu_rob_bju_complete), 64'd1);
      check_eq("iid", 64'(bif.exu_rtu_rob_bju_iid), 64'(mq[0].op.iid));
      check_eq("mispred", 64'(bif.exu_rtu_rob_bju_mispred), 64'(mis));
      check_eq("wb_vld", 64'(bif.exu_idu_rf_bju_wb_vld), 64'(wbv));
      if (wbv) begin
        check_eq("wb_preg", 64'(bif.exu_idu_rf_bju_wb_preg), 64'(mq[0].op.pdst));
        check_eq("wb_data", bif.exu_idu_rf_bju_wb_data, lnk);
      end
    end else begin
      check_eq("complete_idle", 64'(bif.exu_rtu_rob_bju_complete), 64'd0);
      check_eq("wb_vld_idle", 64'(bif.exu_idu_rf_bju_wb_vld), 64'd0);
    end
    check_eq("pcjump_vld", 64'(bif.exu_idu_rf_bju_pcjump_vld), 64'(m_pulse));
    if (m_pulse) begin
      check_eq("pcjump_addr", bif.exu_idu_rf_bju_pcjump_addr, m_pulse_addr);
    end
  endtask

  // One clock: drive at negedge, check, advance the model, wait for posedge
  task automatic step(input op_t o, input logic vld, input logic rr, input logic fl);
    logic exp_rdy, tk, mis, wbv;
    logic [63:0] tgt, lnk;
    slot_t s;
    @(negedge clk);
    bif.idu_exu_bju_vld         = vld;
    bif.idu_exu_bju_iid         = o.iid;
    bif.idu_exu_bju_opcode      = o.opc;
    bif.idu_exu_bju_funct3      = o.f3;
    bif.idu_exu_bju_pc          = o.pc;
    bif.idu_exu_bju_psrc1_value = o.s1;
    bif.idu_exu_bju_psrc2_value = o.s2;
    bif.idu_exu_bju_imm         = o.imm;
    bif.idu_exu_bju_pdst_vld    = o.pdv;
    bif.idu_exu_bju_pdst        = o.pdst;
    bif.idu_exu_bju_pred_taken  = o.pt;
    bif.idu_exu_bju_pred_addr   = o.paddr;
    bif.rtu_exu_bju_rdy         = rr;
    bif.rtu_global_flush        = fl;
    #1;
    check_outputs();
    exp_rdy = (mq.size() < 2) || rr;
    check_eq("issue_rdy", 64'(bif.idu_exu_bju_rdy), 64'(exp_rdy));
    m_pulse = 1'b0;
    if (fl) begin
      mq.delete();
      m_kill = 1'b0;
    end else begin
      if (mq.size() > 0 && mq[0].in_e2 && rr) void'(mq.pop_front());
      if (mq.size() > 0 && !mq[0].in_e2) begin
        s       = mq[0];
        s.in_e2 = 1'b1;
        mq[0]   = s;
        ref_op(s.op, tk, tgt, mis, wbv, lnk);
        if (mis) begin
          m_pulse      = 1'b1;
          m_pulse_addr = tk ? tgt : lnk;
          m_kill       = 1'b1;
          while (mq.size() > 1) void'(mq.pop_back());
        end
      end
      if (vld && exp_rdy && !m_kill) begin
        s.op    = o;
        s.in_e2 = 1'b0;
        mq.push_back(s);
      end
    end
    @(posedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_complete"}, 64'(bif.exu_rtu_rob_bju_complete), 64'd0);
    check_eq({tag, "_iid"}, 64'(bif.exu_rtu_rob_bju_iid), 64'd0);
    check_eq({tag, "_mispred"}, 64'(bif.exu_rtu_rob_bju_mispred), 64'd0);
    check_eq({tag, "_wb_vld"}, 64'(bif.exu_idu_rf_bju_wb_vld), 64'd0);
    check_eq({tag, "_wb_preg"}, 64'(bif.exu_idu_rf_bju_wb_preg), 64'd0);
    check_eq({tag, "_wb_data"}, bif.exu_idu_rf_bju_wb_data, 64'd0);
    check_eq({tag, "_pcjump_vld"}, 64'(bif.exu_idu_rf_bju_pcjump_vld), 64'd0);
    check_eq({tag, "_pcjump_addr"}, bif.exu_idu_rf_bju_pcjump_addr, 64'd0);
  endtask

  initial begin
    op_t idle, o, b1, b2, b3;
    logic fl;
    n_checks = 0;
    n_errors = 0;
    m_kill   = 1'b0;
    m_pulse  = 1'b0;
    m_pulse_addr = 64'd0;
    next_iid = 5'd0;
    idle     = '0;
    rst      = 1'b1;
    bif.rtu_global_flush = 1'b0;
    bif.idu_exu_bju_vld  = 1'b0;
    bif.rtu_exu_bju_rdy  = 1'b1;
    bif.idu_exu_bju_iid = '0; bif.idu_exu_bju_opcode = '0; bif.idu_exu_bju_funct3 = '0;
    bif.idu_exu_bju_pc = '0; bif.idu_exu_bju_psrc1_value = '0; bif.idu_exu_bju_psrc2_value = '0;
    bif.idu_exu_bju_imm = '0; bif.idu_exu_bju_pdst_vld = 1'b0; bif.idu_exu_bju_pdst = '0;
    bif.idu_exu_bju_pred_taken = 1'b0; bif.idu_exu_bju_pred_addr = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check_reset_values("rst");
    check_eq("rst_rdy", 64'(bif.idu_exu_bju_rdy), 64'd1);
    rst = 1'b0;

    // BEQ taken but predicted not-taken: redirect to 0x1040, then kill
    o = mk_op(5'd1, 7'b1100011, 3'b000, 64'h1000, 64'd5, 64'd5, 64'h40, 1'b0, 6'd0, 1'b0, 64'd0);
    step(o, 1'b1, 1'b1, 1'b0);
    step(idle, 1'b0, 1'b1, 1'b0);
    #2;
    check_eq("beq_complete", 64'(bif.exu_rtu_rob_bju_complete), 64'd1);
    check_eq("beq_mispred", 64'(bif.exu_rtu_rob_bju_mispred), 64'd1);
    check_eq("beq_pcjump_vld", 64'(bif.exu_idu_rf_bju_pcjump_vld), 64'd1);
    check_eq("beq_pcjump_addr", bif.exu_idu_rf_bju_pcjump_addr, 64'h1040);
    o = mk_op(5'd2, 7'b1101111, 3'b000, 64'h0, 64'd0, 64'd0, 64'h8, 1'b1, 6'd4, 1'b1, 64'h8);
    step(o, 1'b1, 1'b1, 1'b0);
    repeat (3) step(idle, 1'b0, 1'b1, 1'b0);
    step(idle, 1'b0, 1'b1, 1'b1);

    // JALR correctly predicted with link writeback
    o = mk_op(5'd3, 7'b1100111, 3'b000, 64'h3000, 64'h2001, 64'd0, 64'h10, 1'b1, 6'd7, 1'b1, 64'h2010);
    step(o, 1'b1, 1'b1, 1'b0);
    step(idle, 1'b0, 1'b1, 1'b0);
    #2;
    check_eq("jalr_mispred", 64'(bif.exu_rtu_rob_bju_mispred), 64'd0);
    check_eq("jalr_pcjump", 64'(bif.exu_idu_rf_bju_pcjump_vld), 64'd0);
    check_eq("jalr_wb_vld", 64'(bif.exu_idu_rf_bju_wb_vld), 64'd1);
    check_eq("jalr_wb_preg", 64'(bif.exu_idu_rf_bju_wb_preg), 64'd7);
    check_eq("jalr_wb_data", bif.exu_idu_rf_bju_wb_data, 64'h3004);
    step(idle, 1'b0, 1'b1, 1'b0);

    // BLTU vs BLT on 1 and all-ones
    o = mk_op(5'd4, 7'b1100011, 3'b110, 64'h500, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h20, 1'b0, 6'd0, 1'b0, 64'd0);
    step(o, 1'b1, 1'b1, 1'b0);
    step(idle, 1'b0, 1'b1, 1'b0);
    #2;
    check_eq("bltu_mispred", 64'(bif.exu_rtu_rob_bju_mispred), 64'd1);
    step(idle, 1'b0, 1'b1, 1'b1);
    o = mk_op(5'd5, 7'b1100011, 3'b100, 64'h500, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h20, 1'b0, 6'd0, 1'b0, 64'd0);
    step(o, 1'b1, 1'b1, 1'b0);
    step(idle, 1'b0, 1'b1, 1'b0);
    #2;
    check_eq("blt_complete", 64'(bif.exu_rtu_rob_bju_complete), 64'd1);
    check_eq("blt_mispred", 64'(bif.exu_rtu_rob_bju_mispred), 64'd0);
    check_eq("blt_pcjump", 64'(bif.exu_idu_rf_bju_pcjump_vld), 64'd0);

    // Three correctly predicted BNEs under ROB backpressure
    b1 = mk_op(5'd11, 7'b1100011, 3'b001, 64'h100, 64'd1, 64'd2, 64'h10, 1'b0, 6'd0, 1'b1, 64'h110);
    b2 = mk_op(5'd12, 7'b1100011, 3'b001, 64'h200, 64'd3, 64'd4, 64'h10, 1'b0, 6'd0, 1'b1, 64'h210);
    b3 = mk_op(5'd13, 7'b1100011, 3'b001, 64'h300, 64'd5, 64'd6, 64'h10, 1'b0, 6'd0, 1'b1, 64'h310);
    step(b1, 1'b1, 1'b1, 1'b0);
    step(b2, 1'b1, 1'b0, 1'b0);
    step(b3, 1'b1, 1'b0, 1'b0);
    step(b3, 1'b1, 1'b0, 1'b0);
    #2;
    check_eq("bp_iid_held", 64'(bif.exu_rtu_rob_bju_iid), 64'd11);
    step(b3, 1'b1, 1'b1, 1'b0);
    repeat (3) step(idle, 1'b0, 1'b1, 1'b0);

    // Mispredict in E2 followed by flush, then a clean JAL
    o = mk_op(5'd20, 7'b1100011, 3'b000, 64'h1000, 64'd5, 64'd5, 64'h40, 1'b0, 6'd0, 1'b0, 64'd0);
    step(o, 1'b1, 1'b1, 1'b0);
    step(idle, 1'b0, 1'b0, 1'b0);
    step(idle, 1'b0, 1'b0, 1'b1);
    #2;
    check_reset_values("flush");
    o = mk_op(5'd21, 7'b1101111, 3'b000, 64'h0, 64'd0, 64'd0, 64'h8, 1'b1, 6'd3, 1'b1, 64'h8);
    step(o, 1'b1, 1'b1, 1'b0);
    step(idle, 1'b0, 1'b1, 1'b0);
    #2;
    check_eq("jal_complete", 64'(bif.exu_rtu_rob_bju_complete), 64'd1);
    check_eq("jal_mispred", 64'(bif.exu_rtu_rob_bju_mispred), 64'd0);
    check_eq("jal_pcjump", 64'(bif.exu_idu_rf_bju_pcjump_vld), 64'd0);
    check_eq("jal_wb_data", bif.exu_idu_rf_bju_wb_data, 64'h4);

    // Non-branch opcode is NOP-class
    o = mk_op(5'd22, 7'b0110011, 3'b000, 64'h40, 64'd1, 64'd1, 64'h4, 1'b1, 6'd9, 1'b1, 64'h44);
    step(o, 1'b1, 1'b1, 1'b0);
    step(idle, 1'b0, 1'b1, 1'b0);
    #2;
    check_eq("nop_complete", 64'(bif.exu_rtu_rob_bju_complete), 64'd1);
    check_eq("nop_wb_vld", 64'(bif.exu_idu_rf_bju_wb_vld), 64'd0);
    check_eq("nop_pcjump", 64'(bif.exu_idu_rf_bju_pcjump_vld), 64'd0);
    check_eq("nop_mispred", 64'(bif.exu_rtu_rob_bju_mispred), 64'd0);
    step(idle, 1'b0, 1'b1, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      fl = (m_kill && ($urandom_range(0, 3) == 0)) || ($urandom_range(0, 49) == 0);
      o  = rand_op(next_iid);
      step(o, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 9) < 7), fl);
      next_iid = next_iid + 5'd1;
    end

    // Asynchronous reset while an op sits in E2
    step(idle, 1'b0, 1'b1, 1'b1);
    o = mk_op(5'd30, 7'b1101111, 3'b000, 64'h80, 64'd0, 64'd0, 64'h8, 1'b1, 6'd5, 1'b1, 64'h88);
    step(o, 1'b1, 1'b1, 1'b0);
    step(idle, 1'b0, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check_reset_values("arst");
    check_eq("arst_rdy", 64'(bif.idu_exu_bju_rdy), 64'd1);
    mq.delete();
    m_kill  = 1'b0;
    m_pulse = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      o = rand_op(next_iid);
      step(o, 1'b1, 1'b1, m_kill);
      next_iid = next_iid + 5'd1;
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/exu_bju_pipe.md
# exu_bju_pipe

Parametrised, two-stage branch/jump unit for the EXU. It accepts one branch-type micro-op per cycle from the IDU over a valid/ready handshake and resolves JAL, JALR and conditional branches. It checks the result against the front-end prediction and issues a single-cycle redirect on a mispredict. It writes the link register and reports completion to the ROB, and holds completion under ROB backpressure.

## Interface
Parameters:
- XLEN, 64, datapath and address width.
- IID_W, 5, ROB instruction-id width.
- PREG_W, 6, physical register index width.

Ports:
- clk  in  1  clock.
- rst_clk  in  1  asynchronous reset, active-high.
- rtu_global_flush  in  1  kills all in-flight state and clears kill mode.
- idu_exu_bju_vld  in  1  issue valid.
- idu_exu_bju_rdy  out  1  issue ready.
- idu_exu_bju_iid  in  IID_W  ROB id.
- idu_exu_bju_opcode  in  7  major opcode.
- idu_exu_bju_funct3  in  3  condition / sub-op.
- idu_exu_bju_pc  in  XLEN  instruction PC.
- idu_exu_bju_psrc1_value, idu_exu_bju_psrc2_value  in  XLEN  operands.
- idu_exu_bju_pdst_vld  in  1  link write requested.
- idu_exu_bju_pdst  in  PREG_W  link destination.
- idu_exu_bju_imm  in  XLEN  sign-extended immediate.
- idu_exu_bju_pred_taken  in  1  front-end prediction.
- idu_exu_bju_pred_addr  in  XLEN  predicted target.
- rtu_exu_bju_rdy  in  1  ROB accepts completion.
- exu_rtu_rob_bju_complete  out  1  completion valid.
- exu_rtu_rob_bju_iid  out  IID_W  completing id.
- exu_rtu_rob_bju_mispred  out  1  completing op mispredicted.
- exu_idu_rf_bju_wb_vld  out  1  link write, same cycle as complete.
- exu_idu_rf_bju_wb_preg  out  PREG_W  link write register.
- exu_idu_rf_bju_wb_data  out  XLEN  link write data.
- exu_idu_rf_bju_pcjump_vld  out  1  redirect pulse.
- exu_idu_rf_bju_pcjump_addr  out  XLEN  redirect address.

## Operation
- Decode:
  - JAL is opcode 1101111.
  - JALR is opcode 1100111 with funct3 000.
  - BRANCH is opcode 1100011.
  - Any other opcode, and JALR with nonzero funct3, is NOP-class: it completes with no writeback, no redirect and mispred=0.
- Branch conditions by funct3:
  - 000 eq, 001 ne, 100 signed lt, 101 signed ge, 110 unsigned lt, 111 unsigned ge.
  - 010 and 011 are never taken.
- Arithmetic, all modulo 2^XLEN:
  - link = pc+4.
  - JAL and BRANCH target = pc+imm.
  - JALR target = (src1+imm) with bit0 cleared.
  - JAL and JALR are always taken.
- Correct path: actual_next = taken ? target : pc+4.
- Mispredict: taken≠pred_taken, or taken & pred_taken & target≠pred_addr. NOP-class ops never mispredict.
- Redirect address = actual_next.
- Writeback: wb_vld = pdst_vld & (JAL|JALR) & complete. wb_data = link.
- Pipeline:
  - E1 captures the issued op.
  - E2 holds the resolved result and drives all outputs.
  - E1 advances into E2 when E2 is empty or rtu_exu_bju_rdy=1.
  - idu_exu_bju_rdy = !E1_vld | E1_advance.
- Kill FSM, states NORMAL and KILL:
  - NORMAL→KILL on the edge at which a mispredicting op loads into E2.
  - At that same edge, any op entering or remaining in E1 is discarded as younger wrong-path.
  - In KILL, rdy=1 and accepted issues are dropped.
  - KILL→NORMAL only on rtu_global_flush.
- Flush: rtu_global_flush clears E1_vld, E2_vld and the kill state at the clock edge. An issue presented in the flush cycle is dropped.

## Timing
- Reset values:
  - All valids, complete, mispred, wb_vld and pcjump_vld are 0.
  - iid, preg, data and addr outputs are 0.
  - FSM is NORMAL.
  - rdy is 1.
- Latency: issue accepted at edge N; result reaches E2 at edge N+1; complete is visible in cycle N+1.
- Throughput: 1 op/cycle while rtu_exu_bju_rdy=1.
- Backpressure:
  - While E2 is valid and rtu_exu_bju_rdy=0, complete, iid, mispred and wb outputs hold stable.
  - E1 may hold one more op, so rdy drops only when both E1 and E2 are full.
- Redirect:
  - pcjump_vld is a one-cycle pulse in the first cycle E2 holds a mispredicting op.
  - It is never repeated while completion is stalled.
- Simultaneous E2 handshake and E1 advance: E2 is replaced at the edge with no bubble.
- Flush and issue in the same cycle: flush wins.
- Reset asserted mid-operation clears all state immediately, asynchronously.

## Test plan
- BEQ with pc=0x1000, imm=0x40, src1=src2=5, pred_taken=0:
  - Complete at N+1, mispred=1.
  - pcjump_vld pulse with addr 0x1040.
  - The next issued op is dropped until flush.
- JALR with src1=0x2001, imm=0x10, pdst=7, pred_taken=1, pred_addr=0x2010, pc=0x3000:
  - mispred=0, no redirect.
  - wb_vld=1, preg 7, data 0x3004.
- BLTU with src1=1, src2=0xFFFF_FFFF_FFFF_FFFF: taken. BLT with the same operands: not taken. pred_taken=0 for both; mispred=1 then 0.
- Three back-to-back BNE ops, each correctly predicted, with rtu_exu_bju_rdy=0 for 3 cycles:
  - rdy goes 0 after the second accept.
  - E2 outputs stay stable.
  - All three complete in order once ready returns.
- Mispredicting branch in E2 with rtu_global_flush in the next cycle:
  - Outputs return to reset values and FSM is NORMAL.
  - A subsequent JAL pc=0x0, imm=0x8, pred_taken=1, pred_addr=0x8 completes normally with no redirect and wb_data 0x4.
- Opcode 0110011 issued: completes with wb_vld=0, pcjump_vld=0, mispred=0.
